// File: rtl/synth_strobe_gen.sv
// synth_strobe_gen: single-clock strobe generator for the synth engine.
// Two fractional phase accumulators produce one-cycle oscillator and
// envelope slot enables, with slot index counters and burst/free-run
// sweep control (abort, completion and overrun reporting).
module synth_strobe_gen #(
   parameter int VOICES    = 8,
   parameter int V_OSC     = 4,
   parameter int V_ENVS    = 8,
   parameter int V_WIDTH   = 3,
   parameter int O_WIDTH   = 2,
   parameter int E_WIDTH   = 3,
   parameter int ACC_WIDTH = 24,
   parameter int INC_OSC   = 32,
   parameter int INC_ENVS  = 64
) (
   input  logic                       AUDIO_CLK,
   input  logic                       reset_reg,
   input  logic                       trig,
   input  logic                       free_run,
   input  logic                       stop,
   input  logic                       clr_ovr,
   output logic                       busy,
   output logic                       osc_stb,
   output logic                       env_stb,
   output logic [V_WIDTH+O_WIDTH-1:0] xvxo,
   output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
   output logic                       xxxx_zero,
   output logic                       frame,
   output logic                       done,
   output logic                       overrun
);

   localparam int XO = V_WIDTH + O_WIDTH;
   localparam int XE = V_WIDTH + E_WIDTH;
   localparam logic [XO-1:0]        LAST_O = XO'(VOICES * V_OSC - 1);
   localparam logic [XE-1:0]        LAST_E = XE'(VOICES * V_ENVS - 1);
   localparam logic [ACC_WIDTH:0]   INC_O_X = (ACC_WIDTH + 1)'(INC_OSC);
   localparam logic [ACC_WIDTH:0]   INC_E_X = (ACC_WIDTH + 1)'(INC_ENVS);
   localparam logic [ACC_WIDTH-1:0] INC_O_A = ACC_WIDTH'(INC_OSC);
   localparam logic [ACC_WIDTH-1:0] INC_E_A = ACC_WIDTH'(INC_ENVS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic                 r_trig_d;
   logic                 r_mode_q;
   logic [ACC_WIDTH-1:0] r_acc_o;
   logic [ACC_WIDTH-1:0] r_acc_e;
   logic                 r_osc_stb;
   logic                 r_env_stb;
   logic [XO-1:0]        r_xvxo;
   logic [XE-1:0]        r_xxxx;
   logic                 r_xxxx_zero;
   logic                 r_frame;
   logic                 r_overrun;

   logic                 w_start_req;
   logic [ACC_WIDTH:0]   w_sum_o;
   logic [ACC_WIDTH:0]   w_sum_e;
   logic                 w_c_o;
   logic                 w_c_e;
   logic                 w_e_wrap;
   logic                 w_load;
   logic                 w_step;
   logic                 w_ovr_set;

   logic [ACC_WIDTH-1:0] w_acc_o_nxt;
   logic [ACC_WIDTH-1:0] w_acc_e_nxt;
   logic                 w_osc_stb_nxt;
   logic                 w_env_stb_nxt;
   logic [XO-1:0]        w_xvxo_nxt;
   logic [XE-1:0]        w_xxxx_nxt;
   logic                 w_frame_nxt;

   assign w_start_req = trig & ~r_trig_d;
   assign w_sum_o     = {1'b0, r_acc_o} + INC_O_X;
   assign w_sum_e     = {1'b0, r_acc_e} + INC_E_X;
   assign w_c_o       = w_sum_o[ACC_WIDTH];
   assign w_c_e       = w_sum_e[ACC_WIDTH];
   assign w_e_wrap    = w_c_e && (r_xxxx == LAST_E);

   // Sweep control: next state, start/step qualifiers and overrun request.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_ovr_set   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_req) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end
         end
         ST_RUN: begin
            w_ovr_set = w_start_req;
            if (stop) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_step = 1'b1;
               if (w_e_wrap && !r_mode_q) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // The completion cycle accepts a restart; only an abort turns it into an overrun.
            if (stop) begin
               w_state_nxt = ST_IDLE;
               w_ovr_set   = w_start_req;
            end else if (w_start_req) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath next values: start reload, per-cycle accumulation, or clear.
   always_comb begin
      w_acc_o_nxt   = '0;
      w_acc_e_nxt   = '0;
      w_osc_stb_nxt = 1'b0;
      w_env_stb_nxt = 1'b0;
      w_xvxo_nxt    = '0;
      w_xxxx_nxt    = '0;
      w_frame_nxt   = 1'b0;
      if (w_load) begin
         // The start edge is the first accumulation step from zero phase,
         // so the first strobe lands 2^ACC_WIDTH/INC cycles into the sweep.
         w_acc_o_nxt = INC_O_A;
         w_acc_e_nxt = INC_E_A;
      end else if (w_step) begin
         w_osc_stb_nxt = w_c_o;
         w_env_stb_nxt = w_c_e;
         w_frame_nxt   = w_e_wrap;
         if (w_c_o) begin
            w_xvxo_nxt = (r_xvxo == LAST_O) ? '0 : r_xvxo + XO'(1);
         end else begin
            w_xvxo_nxt = r_xvxo;
         end
         if (w_c_e) begin
            w_xxxx_nxt = (r_xxxx == LAST_E) ? '0 : r_xxxx + XE'(1);
         end else begin
            w_xxxx_nxt = r_xxxx;
         end
         if (!(w_e_wrap && !r_mode_q)) begin
            w_acc_o_nxt = w_sum_o[ACC_WIDTH-1:0];
            w_acc_e_nxt = w_sum_e[ACC_WIDTH-1:0];
         end
      end
   end

   // Sweep state register.
   always_ff @(posedge AUDIO_CLK or posedge reset_reg) begin
      if (reset_reg) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers: edge detect, mode, accumulators, strobes, indices, flags.
   always_ff @(posedge AUDIO_CLK or posedge reset_reg) begin
      if (reset_reg) begin
         r_trig_d    <= 1'b0;
         r_mode_q    <= 1'b0;
         r_acc_o     <= '0;
         r_acc_e     <= '0;
         r_osc_stb   <= 1'b0;
         r_env_stb   <= 1'b0;
         r_xvxo      <= '0;
         r_xxxx      <= '0;
         r_xxxx_zero <= 1'b1;
         r_frame     <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_trig_d    <= trig;
         if (w_load) begin
            r_mode_q <= free_run;
         end
         r_acc_o     <= w_acc_o_nxt;
         r_acc_e     <= w_acc_e_nxt;
         r_osc_stb   <= w_osc_stb_nxt;
         r_env_stb   <= w_env_stb_nxt;
         r_xvxo      <= w_xvxo_nxt;
         r_xxxx      <= w_xxxx_nxt;
         r_xxxx_zero <= (w_xxxx_nxt == '0);
         r_frame     <= w_frame_nxt;
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (clr_ovr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign osc_stb   = r_osc_stb;
   assign env_stb   = r_env_stb;
   assign xvxo      = r_xvxo;
   assign xxxx      = r_xxxx;
   assign xxxx_zero = r_xxxx_zero;
   assign frame     = r_frame;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_synth_strobe_gen.sv
// tb_synth_strobe_gen: two instances (integer and fractional envelope rate)
// driven by shared directed and random stimulus, checked every cycle against
// an arithmetic sweep model (strobe counts from floor(n*INC/2^ACC_WIDTH)).
module tb_synth_strobe_gen;

   localparam int AW  = 8;
   localparam int MOD = 256;
   localparam int IO  = 32;
   localparam int NO  = 4;
   localparam int NE  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       trig;
   logic       free_run;
   logic       stop;
   logic       clr_ovr;
   logic [1:0] busy_v;
   logic [1:0] osc_v;
   logic [1:0] env_v;
   logic [1:0] zero_v;
   logic [1:0] frame_v;
   logic [1:0] done_v;
   logic [1:0] ovr_v;
   logic [3:0] xvxo_v;
   logic [3:0] xxxx_v;

   int n_cmp = 0;
   int n_mis = 0;

   // behavioural model: busy flag, busy-cycle number (1 = first busy cycle), mode, overrun
   int mb[2];
   int mn[2];
   int mm[2];
   int movr[2];
   int m_trig_d;
   int inc_e[2] = '{64, 96};
   bit btb_done;

   always #5 clk = ~clk;

   synth_strobe_gen #(
      .VOICES(2), .V_OSC(2), .V_ENVS(2), .V_WIDTH(1), .O_WIDTH(1), .E_WIDTH(1),
      .ACC_WIDTH(AW), .INC_OSC(IO), .INC_ENVS(64)
   ) dut0 (
      .AUDIO_CLK(clk), .reset_reg(rst), .trig(trig), .free_run(free_run),
      .stop(stop), .clr_ovr(clr_ovr), .busy(busy_v[0]), .osc_stb(osc_v[0]),
      .env_stb(env_v[0]), .xvxo(xvxo_v[1:0]), .xxxx(xxxx_v[1:0]),
      .xxxx_zero(zero_v[0]), .frame(frame_v[0]), .done(done_v[0]), .overrun(ovr_v[0])
   );

   synth_strobe_gen #(
      .VOICES(2), .V_OSC(2), .V_ENVS(2), .V_WIDTH(1), .O_WIDTH(1), .E_WIDTH(1),
      .ACC_WIDTH(AW), .INC_OSC(IO), .INC_ENVS(96)
   ) dut1 (
      .AUDIO_CLK(clk), .reset_reg(rst), .trig(trig), .free_run(free_run),
      .stop(stop), .clr_ovr(clr_ovr), .busy(busy_v[1]), .osc_stb(osc_v[1]),
      .env_stb(env_v[1]), .xvxo(xvxo_v[3:2]), .xxxx(xxxx_v[3:2]),
      .xxxx_zero(zero_v[1]), .frame(frame_v[1]), .done(done_v[1]), .overrun(ovr_v[1])
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int strobes_by(input int n, input int inc);
      return (n * inc) / MOD;
   endfunction

   function automatic bit exp_env(input int i);
      if (!mb[i]) return 1'b0;
      return strobes_by(mn[i], inc_e[i]) != strobes_by(mn[i] - 1, inc_e[i]);
   endfunction

   function automatic bit exp_frame(input int i);
      return exp_env(i) && (strobes_by(mn[i], inc_e[i]) % NE == 0);
   endfunction

   function automatic bit exp_done(input int i);
      return exp_frame(i) && (mm[i] == 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mb[i] = 0; mn[i] = 0; mm[i] = 0; movr[i] = 0;
      end
      m_trig_d = 0;
   endtask

   task automatic check_outputs();
      for (int i = 0; i < 2; i++) begin
         int e_x;
         int e_v;
         bit e_o;
         e_x = mb[i] ? strobes_by(mn[i], inc_e[i]) % NE : 0;
         e_v = mb[i] ? strobes_by(mn[i], IO) % NO : 0;
         e_o = mb[i] && (strobes_by(mn[i], IO) != strobes_by(mn[i] - 1, IO));
         check_val($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(mb[i]));
         check_val($sformatf("env_stb[%0d]", i), 32'(env_v[i]), 32'(exp_env(i)));
         check_val($sformatf("osc_stb[%0d]", i), 32'(osc_v[i]), 32'(e_o));
         check_val($sformatf("xxxx[%0d]", i), 32'(xxxx_v[2*i +: 2]), 32'(e_x));
         check_val($sformatf("xvxo[%0d]", i), 32'(xvxo_v[2*i +: 2]), 32'(e_v));
         check_val($sformatf("xxxx_zero[%0d]", i), 32'(zero_v[i]), 32'(e_x == 0));
         check_val($sformatf("frame[%0d]", i), 32'(frame_v[i]), 32'(exp_frame(i)));
         check_val($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(exp_done(i)));
         check_val($sformatf("overrun[%0d]", i), 32'(ovr_v[i]), 32'(movr[i]));
      end
   endtask

   task automatic model_advance();
      bit sr;
      sr = trig && (m_trig_d == 0);
      for (int i = 0; i < 2; i++) begin
         bit dn;
         bit ovs;
         dn  = exp_done(i);
         ovs = sr && (mb[i] != 0) && (!dn || stop);
         if (mb[i] == 0) begin
            if (sr) begin
               mb[i] = 1; mn[i] = 1; mm[i] = free_run;
            end
         end else if (stop) begin
            mb[i] = 0; mn[i] = 0;
         end else if (dn) begin
            if (sr) begin
               mn[i] = 1; mm[i] = free_run;
            end else begin
               mb[i] = 0; mn[i] = 0;
            end
         end else begin
            mn[i]++;
         end
         if (ovs) movr[i] = 1;
         else if (clr_ovr) movr[i] = 0;
      end
      m_trig_d = trig;
   endtask

   // check the current cycle at the falling edge, then apply this cycle's inputs
   task automatic step(input logic t, input logic fr, input logic sp, input logic co);
      @(negedge clk);
      check_outputs();
      trig = t; free_run = fr; stop = sp; clr_ovr = co;
      model_advance();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; trig = 1'b0; free_run = 1'b0; stop = 1'b0; clr_ovr = 1'b0;
      btb_done = 1'b0;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         check_outputs();
      end
      rst = 1'b0;

      // burst sweep
      step(1, 0, 0, 0);
      repeat (22) step(1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0);

      // free-run for three frames, then abort
      step(1, 1, 0, 0);
      for (int k = 0; k < 80; k++) begin
         if (mb[0] != 0 && mn[0] == 52) break;
         step(1, 1, 0, 0);
      end
      step(1, 1, 1, 0);
      repeat (4) step(0, 0, 0, 0);

      // overrun from a second edge in busy cycle 6, then clear
      step(1, 0, 0, 0);
      for (int k = 0; k < 24; k++) step(mb[0] != 0 && mn[0] == 6, 0, 0, 0);
      step(0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0);

      // back-to-back: edge aligned to the completion cycle
      step(1, 0, 0, 0);
      for (int k = 0; k < 40; k++) begin
         logic t;
         t = !btb_done && exp_done(0);
         if (t) btb_done = 1'b1;
         step(t, 0, 0, 0);
      end

      // asynchronous reset in busy cycle 9
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         if (mb[0] != 0 && mn[0] == 9) break;
         step(1, 0, 0, 0);
      end
      @(negedge clk);
      check_outputs();
      #2;
      rst = 1'b1; trig = 1'b0; stop = 1'b0; clr_ovr = 1'b0; free_run = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      check_outputs();
      rst = 1'b0;
      repeat (12) step(0, 0, 0, 0);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         logic t;
         t = ($urandom % 5 == 0) ? ~trig : trig;
         step(t, 1'($urandom % 2), 1'($urandom % 40 == 0), 1'($urandom % 16 == 0));
      end
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
